// File: rtl/capture_pack_if.sv
// capture_pack_if: capture sample stream plus burst request / FIFO read bus.
// master = capture_pack side, slave = capture source and SDRAM write arbiter.
interface capture_pack_if #(
    parameter int FIFO_AW = 9
) ();
    logic             capture_valid;
    logic [15:0]      capture_data;
    logic             capture_done;
    logic             burst_req;
    logic [FIFO_AW:0] burst_len;
    logic             burst_ack;
    logic             rd_en;
    logic [31:0]      rd_data;
    logic [FIFO_AW:0] fifo_level;

    modport master (
        input  capture_valid, capture_data, capture_done,
        input  burst_ack, rd_en,
        output burst_req, burst_len, rd_data, fifo_level
    );

    modport slave (
        output capture_valid, capture_data, capture_done,
        output burst_ack, rd_en,
        input  burst_req, burst_len, rd_data, fifo_level
    );
endinterface

// File: rtl/capture_pack.sv
// capture_pack: packs 16-bit capture samples into 32-bit words, buffers them
// in a first-word-fall-through FIFO and requests SDRAM write bursts.
// Ports: core_clk, core_rst (sync, active high), sample_en (run enable level),
//   bus (capture_pack_if.master: capture stream in, burst_req/len/ack,
//   rd_en/rd_data/fifo_level), word_cnt, overflow (sticky), pack_done (pulse).
// Option: define CAPTURE_PACK_TRAILER_EN to append a sample-count trailer word.
module capture_pack #(
    parameter int FIFO_AW   = 9,
    parameter int BURST_LEN = 64
) (
    input  logic           core_clk,
    input  logic           core_rst,
    input  logic           sample_en,
    capture_pack_if.master bus,
    output logic [31:0]    word_cnt,
    output logic           overflow,
    output logic           pack_done
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] BLEN    = (FIFO_AW+1)'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPT,
        S_PAD,
        S_PAD2,
        S_DRAIN
    } state_t;

    state_t             state;
    logic               en_q;
    logic [15:0]        half;
    logic               half_vld;
    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               burst_req_q;
    logic [FIFO_AW:0]   burst_len_q;
    logic [FIFO_AW:0]   out_cnt;
`ifdef CAPTURE_PACK_TRAILER_EN
    logic [31:0]        smp_cnt;
`endif

    logic        rise;
    logic        abort;
    logic        take;
    logic        idle_bus;
    logic        wr_req;
    logic [31:0] wr_word;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;

    assign rise     = sample_en & ~en_q;
    assign abort    = ~sample_en & (state != S_IDLE);
    assign take     = (state == S_CAPT) & bus.capture_valid;
    assign idle_bus = ~burst_req_q & (out_cnt == '0);

    always_comb begin
        wr_req  = 1'b0;
        wr_word = '0;
        case (state)
            S_CAPT: begin
                if (take && half_vld) begin
                    wr_req  = 1'b1;
                    wr_word = {bus.capture_data, half};
                end
            end
            S_PAD: begin
                if (half_vld) begin
                    wr_req  = 1'b1;
                    wr_word = {16'h0000, half};
                end
            end
`ifdef CAPTURE_PACK_TRAILER_EN
            S_PAD2: begin
                wr_req  = 1'b1;
                wr_word = smp_cnt;
            end
`endif
            default: ;
        endcase
        if (abort)
            wr_req = 1'b0;
    end

    // A pop on a full FIFO frees the slot the push lands in.
    assign full = (level == DEPTH_L);
    assign pop  = bus.rd_en & (level != '0) & ~abort;
    assign push = wr_req & (~full | pop);
    assign drop = wr_req & full & ~pop;

    assign bus.rd_data    = (level != '0) ? mem[rd_ptr] : 32'h0;
    assign bus.fifo_level = level;
    assign bus.burst_req  = burst_req_q;
    assign bus.burst_len  = burst_len_q;

    always_ff @(posedge core_clk) begin
        if (push)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state       <= S_IDLE;
            en_q        <= 1'b0;
            half        <= '0;
            half_vld    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            word_cnt    <= '0;
            overflow    <= 1'b0;
            pack_done   <= 1'b0;
            burst_req_q <= 1'b0;
            burst_len_q <= '0;
            out_cnt     <= '0;
`ifdef CAPTURE_PACK_TRAILER_EN
            smp_cnt     <= '0;
`endif
        end else begin
            en_q      <= sample_en;
            pack_done <= 1'b0;

            if (push) begin
                wr_ptr   <= wr_ptr + FIFO_AW'(1);
                word_cnt <= word_cnt + 32'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            level <= level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            if (drop)
                overflow <= 1'b1;

            // Outstanding words of the accepted burst, retired by pops.
            if (burst_req_q && bus.burst_ack) begin
                burst_req_q <= 1'b0;
                out_cnt     <= burst_len_q;
            end else if (pop && out_cnt != '0) begin
                out_cnt <= out_cnt - (FIFO_AW+1)'(1);
            end

            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state    <= S_CAPT;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        level    <= '0;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                        half_vld <= 1'b0;
`ifdef CAPTURE_PACK_TRAILER_EN
                        smp_cnt  <= '0;
`endif
                    end
                end
                S_CAPT: begin
                    if (take) begin
`ifdef CAPTURE_PACK_TRAILER_EN
                        smp_cnt <= smp_cnt + 32'd1;
`endif
                        if (!half_vld) begin
                            half     <= bus.capture_data;
                            half_vld <= 1'b1;
                        end else begin
                            half_vld <= 1'b0;
                        end
                    end
                    if (idle_bus && level >= BLEN) begin
                        burst_req_q <= 1'b1;
                        burst_len_q <= BLEN;
                    end
                    if (bus.capture_done)
                        state <= S_PAD;
                end
                S_PAD: begin
                    half_vld <= 1'b0;
`ifdef CAPTURE_PACK_TRAILER_EN
                    state    <= S_PAD2;
`else
                    state    <= S_DRAIN;
`endif
                end
`ifdef CAPTURE_PACK_TRAILER_EN
                S_PAD2: begin
                    state <= S_DRAIN;
                end
`endif
                S_DRAIN: begin
                    if (idle_bus && level == '0) begin
                        state     <= S_IDLE;
                        pack_done <= 1'b1;
                    end else if (idle_bus) begin
                        burst_req_q <= 1'b1;
                        burst_len_q <= (level < BLEN) ? level : BLEN;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Losing sample_en mid-run throws the whole run away.
            if (abort) begin
                state       <= S_IDLE;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                level       <= '0;
                half_vld    <= 1'b0;
                burst_req_q <= 1'b0;
                out_cnt     <= '0;
                pack_done   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_capture_pack.sv
// tb_capture_pack: randomized runs of capture_pack with a scoreboard of
// expected FIFO words and a reader that acts as the SDRAM write arbiter.
module tb_capture_pack;
    localparam int AW    = 4;
    localparam int BL    = 4;
    localparam int DEPTH = 1 << AW;

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic        sample_en;
    logic [31:0] word_cnt;
    logic        overflow;
    logic        pack_done;

    capture_pack_if #(.FIFO_AW(AW)) bus ();

    capture_pack #(.FIFO_AW(AW), .BURST_LEN(BL)) dut (
        .core_clk  (core_clk),
        .core_rst  (core_rst),
        .sample_en (sample_en),
        .bus       (bus.master),
        .word_cnt  (word_cnt),
        .overflow  (overflow),
        .pack_done (pack_done)
    );

    always #5 core_clk = ~core_clk;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          done_cnt = 0;
    bit          done_sent = 1'b0;
    bit          arb_en    = 1'b1;
    logic [31:0] exp_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    // Monitor: every word the reader pops must be the oldest expected word.
    always @(negedge core_clk) begin
        if (pack_done === 1'b1)
            done_cnt++;
        if (bus.rd_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_extra: got %h want none", bus.rd_data);
            end else begin
                chk("rd_data", bus.rd_data, exp_q.pop_front());
            end
        end
    end

    // Arbiter: accept each burst after a short random delay, then pop it.
    initial begin : arb
        bus.burst_ack = 1'b0;
        bus.rd_en     = 1'b0;
        forever begin
            tick();
            if (arb_en && bus.burst_req === 1'b1) begin
                int want;
                int n;
                want = (done_sent && exp_q.size() < BL) ? exp_q.size() : BL;
                chk("burst_len", 32'(bus.burst_len), 32'(want));
                n = int'(bus.burst_len);
                repeat ($urandom_range(0, 2)) tick();
                bus.burst_ack = 1'b1;
                tick();
                bus.burst_ack = 1'b0;
                while (n > 0) begin
                    bus.rd_en = ($urandom_range(0, 3) != 0);
                    tick();
                    if (bus.rd_en)
                        n--;
                end
                bus.rd_en = 1'b0;
            end
        end
    end

    task automatic send(logic [15:0] d, bit with_done);
        bus.capture_valid = 1'b1;
        bus.capture_data  = d;
        if (with_done) begin
            bus.capture_done = 1'b1;
            done_sent        = 1'b1;
        end
        tick();
        bus.capture_valid = 1'b0;
        bus.capture_done  = 1'b0;
        bus.capture_data  = 16'($urandom);
    endtask

    task automatic run(int nsamp, bit tie_done);
        logic [15:0] half;
        logic [15:0] d;
        bit          hv;
        int          nw;
        int          base;
        hv        = 1'b0;
        half      = '0;
        nw        = 0;
        done_sent = 1'b0;
        base      = done_cnt;
        sample_en = 1'b1;
        tick();
        chk("word_cnt_clr", word_cnt, 32'd0);
        chk("overflow_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < nsamp; i++) begin
            while ($urandom_range(0, 1) == 1) tick();
            d = 16'($urandom);
            if (hv) begin
                exp_q.push_back({d, half});
                nw++;
                hv = 1'b0;
            end else begin
                half = d;
                hv   = 1'b1;
            end
            send(d, tie_done && (i == nsamp - 1));
        end
        if (!(tie_done && nsamp > 0)) begin
            bus.capture_done = 1'b1;
            done_sent        = 1'b1;
            tick();
            bus.capture_done = 1'b0;
        end
        if (hv) begin
            exp_q.push_back({16'h0000, half});
            nw++;
        end
`ifdef CAPTURE_PACK_TRAILER_EN
        exp_q.push_back(32'(nsamp));
        nw++;
`endif
        for (int c = 0; c < 3000 && done_cnt == base; c++) tick();
        chk("pack_done_seen", 32'(done_cnt - base), 32'd1);
        repeat (4) tick();
        chk("pack_done_once", 32'(done_cnt - base), 32'd1);
        chk("word_cnt", word_cnt, 32'(nw));
        chk("overflow_run", 32'(overflow), 32'd0);
        chk("level_end", 32'(bus.fifo_level), 32'd0);
        chk("burst_req_end", 32'(bus.burst_req), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        sample_en = 1'b0;
        tick();
        repeat (3) send(16'($urandom), 1'b0);
        chk("idle_ignore_lvl", 32'(bus.fifo_level), 32'd0);
        chk("idle_ignore_cnt", word_cnt, 32'(nw));
    endtask

    task automatic ovf_run();
        logic [15:0] half;
        logic [15:0] d;
        int          base;
        arb_en    = 1'b0;
        done_sent = 1'b0;
        sample_en = 1'b1;
        tick();
        for (int i = 0; i < 2 * DEPTH + 6; i++) begin
            d = 16'($urandom);
            if (i % 2 == 0)
                half = d;
            else if (i / 2 < DEPTH)
                exp_q.push_back({d, half});
            send(d, 1'b0);
        end
        tick();
        chk("ovf_level", 32'(bus.fifo_level), 32'(DEPTH));
        chk("ovf_word_cnt", word_cnt, 32'(DEPTH));
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_burst_req", 32'(bus.burst_req), 32'd1);
        chk("ovf_burst_len", 32'(bus.burst_len), 32'(BL));
        chk("ovf_head", bus.rd_data, exp_q[0]);
        base      = done_cnt;
        sample_en = 1'b0;
        tick();
        exp_q.delete();
        chk("abort_level", 32'(bus.fifo_level), 32'd0);
        chk("abort_burst_req", 32'(bus.burst_req), 32'd0);
        repeat (4) tick();
        chk("abort_no_done", 32'(done_cnt - base), 32'd0);
        arb_en = 1'b1;
    endtask

    initial begin
        core_rst          = 1'b1;
        sample_en         = 1'b0;
        bus.capture_valid = 1'b0;
        bus.capture_data  = '0;
        bus.capture_done  = 1'b0;
        repeat (3) tick();
        chk("rst_burst_req", 32'(bus.burst_req), 32'd0);
        chk("rst_burst_len", 32'(bus.burst_len), 32'd0);
        chk("rst_level", 32'(bus.fifo_level), 32'd0);
        chk("rst_word_cnt", word_cnt, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_pack_done", 32'(pack_done), 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        core_rst = 1'b0;
        tick();
        run(8, 1'b0);
        run(3, 1'b0);
        run(2, 1'b1);
        run(1, 1'b1);
        run(0, 1'b0);
        ovf_run();
        run(5, 1'b0);
        repeat (12)
            run(int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
